pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW detection, mult/div occupancy
// tracking and a saturating stall-cycle counter for a classic 5-stage pipeline.
module pipeline_hazard_ctrl #(
   parameter int RA_W   = 5,
   parameter int FWD_EN = 1,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            id_use_rs,
   input  logic            id_use_rt,
   input  logic            id_muldiv,
   input  logic            id_hilo_read,
   input  logic            id_jump,
   input  logic            ex_branch_taken,
   input  logic            ex_mem_read,
   input  logic            ex_reg_write,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            mem_reg_write,
   input  logic [RA_W-1:0] mem_rd,
   output logic            pc_write,
   output logic            if_id_write,
   output logic            if_id_flush,
   output logic            id_ex_bubble,
   output logic            muldiv_start,
   output logic            muldiv_busy,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [7:0]       MD_LAT_M1 = 8'(MD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

   md_state_e        state_q;
   logic [7:0]       cnt_q;
   logic             busy_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   logic ex_hz_s, mem_hz_s, load_use_s, raw_s, md_conflict_s, stall_s, start_s;

   // Register r = 0 is hardwired zero and never creates a dependency.
   function automatic logic hazard(input logic [RA_W-1:0] src, input logic use_src,
                                   input logic [RA_W-1:0] dst);
      return use_src && (src != {RA_W{1'b0}}) && (src == dst);
   endfunction

   // Hazard detection and priority resolution of the pipeline control outputs.
   always_comb begin
      ex_hz_s       = hazard(id_rs, id_use_rs, ex_rd) | hazard(id_rt, id_use_rt, ex_rd);
      mem_hz_s      = hazard(id_rs, id_use_rs, mem_rd) | hazard(id_rt, id_use_rt, mem_rd);
      load_use_s    = ex_mem_read & ex_reg_write & ex_hz_s;
      if (FWD_EN != 0) begin
         raw_s = load_use_s;
      end else begin
         raw_s = load_use_s | (ex_reg_write & ex_hz_s) | (mem_reg_write & mem_hz_s);
      end
      md_conflict_s = busy_q & (id_muldiv | id_hilo_read);
      stall_s       = (raw_s | md_conflict_s) & ~ex_branch_taken;
      start_s       = id_muldiv & ~stall_s & ~ex_branch_taken;

      if (ex_branch_taken) begin
         pc_write = 1'b1; if_id_write = 1'b1; if_id_flush = 1'b1; id_ex_bubble = 1'b1;
      end else if (stall_s) begin
         pc_write = 1'b0; if_id_write = 1'b0; if_id_flush = 1'b0; id_ex_bubble = 1'b1;
      end else if (id_jump) begin
         pc_write = 1'b1; if_id_write = 1'b1; if_id_flush = 1'b1; id_ex_bubble = 1'b0;
      end else begin
         pc_write = 1'b1; if_id_write = 1'b1; if_id_flush = 1'b0; id_ex_bubble = 1'b0;
      end
      muldiv_start = start_s;

      if (stall_s && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Mult/div occupancy FSM; busy spans exactly MD_LAT cycles after issue.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_s) begin
                  state_q <= BUSY;
                  cnt_q   <= MD_LAT_M1;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            BUSY: begin
               if (cnt_q == 8'd0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q - 8'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= 8'd0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign muldiv_busy = busy_q;
   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two instances (forwarding/16-bit counter and
// no-forwarding/4-bit counter) share stimulus; a monitor checks each cycle.
module tb_pipeline_hazard_ctrl;

   logic clk, reset_n;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
   logic id_use_rs, id_use_rt, id_muldiv, id_hilo_read, id_jump;
   logic ex_branch_taken, ex_mem_read, ex_reg_write, mem_reg_write;

   logic a_pcw, a_ifw, a_flush, a_bub, a_start, a_busy;
   logic [15:0] a_cnt;
   logic b_pcw, b_ifw, b_flush, b_bub, b_start, b_busy;
   logic [3:0] b_cnt;

   pipeline_hazard_ctrl #(.RA_W(5), .FWD_EN(1), .MD_LAT(4), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_muldiv(id_muldiv),
      .id_hilo_read(id_hilo_read), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_flush), .id_ex_bubble(a_bub),
      .muldiv_start(a_start), .muldiv_busy(a_busy), .stall_count(a_cnt));

   pipeline_hazard_ctrl #(.RA_W(5), .FWD_EN(0), .MD_LAT(4), .CNT_W(4)) dut_nf (
      .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_muldiv(id_muldiv),
      .id_hilo_read(id_hilo_read), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_flush), .id_ex_bubble(b_bub),
      .muldiv_start(b_start), .muldiv_busy(b_busy), .stall_count(b_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rs, rt, exrd, memrd;
      logic urs, urt, md, hilo, jmp, br, exmr, exrw, memrw;
   } in_t;

   typedef struct {
      string       nm;
      logic        pcw, ifw, flush, bub, st, bz, pcw_b, bub_b;
      logic [15:0] cnt_a;
      logic [3:0]  cnt_b;
   } exp_t;

   exp_t q[$];
   int n_total = 0;
   int n_pass  = 0;
   logic [15:0] m_cnt_a = 16'd0;
   logic [3:0]  m_cnt_b = 4'd0;

   task automatic chk(input string nm, input string f, input logic [15:0] got, input logic [15:0] want);
      n_total++;
      if (got !== want) $display("FAIL %s.%s got=%0h want=%0h", nm, f, got, want);
      else n_pass++;
   endtask

   // One cycle of stimulus: sa/sb = instance A/B stalls, st = issue, bz = unit busy.
   task automatic step(input string nm, input in_t v, input logic rst,
                       input logic sa, input logic sb, input logic st, input logic bz);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n = ~rst;
      id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs; id_use_rt = v.urt;
      id_muldiv = v.md; id_hilo_read = v.hilo; id_jump = v.jmp;
      ex_branch_taken = v.br; ex_mem_read = v.exmr; ex_reg_write = v.exrw;
      ex_rd = v.exrd; mem_reg_write = v.memrw; mem_rd = v.memrd;
      if (rst) begin
         m_cnt_a = 16'd0;
         m_cnt_b = 4'd0;
      end
      e.nm = nm;
      if (v.br) begin
         e.pcw = 1'b1; e.ifw = 1'b1; e.flush = 1'b1; e.bub = 1'b1;
      end else if (sa) begin
         e.pcw = 1'b0; e.ifw = 1'b0; e.flush = 1'b0; e.bub = 1'b1;
      end else if (v.jmp) begin
         e.pcw = 1'b1; e.ifw = 1'b1; e.flush = 1'b1; e.bub = 1'b0;
      end else begin
         e.pcw = 1'b1; e.ifw = 1'b1; e.flush = 1'b0; e.bub = 1'b0;
      end
      e.pcw_b = v.br | ~sb;
      e.bub_b = v.br | sb | (v.jmp & 1'b0);
      e.st = st; e.bz = bz;
      e.cnt_a = m_cnt_a; e.cnt_b = m_cnt_b;
      q.push_back(e);
      if (!rst) begin
         if (sa && m_cnt_a != 16'hFFFF) m_cnt_a = m_cnt_a + 16'd1;
         if (sb && m_cnt_b != 4'hF) m_cnt_b = m_cnt_b + 4'd1;
      end
   endtask

   // Monitor: compare the DUT outputs against the oldest pending expectation.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.nm, "pc_write",      {15'd0, a_pcw},   {15'd0, e.pcw});
         chk(e.nm, "if_id_write",   {15'd0, a_ifw},   {15'd0, e.ifw});
         chk(e.nm, "if_id_flush",   {15'd0, a_flush}, {15'd0, e.flush});
         chk(e.nm, "id_ex_bubble",  {15'd0, a_bub},   {15'd0, e.bub});
         chk(e.nm, "muldiv_start",  {15'd0, a_start}, {15'd0, e.st});
         chk(e.nm, "muldiv_busy",   {15'd0, a_busy},  {15'd0, e.bz});
         chk(e.nm, "stall_count",   a_cnt,            e.cnt_a);
         chk(e.nm, "nf_pc_write",   {15'd0, b_pcw},   {15'd0, e.pcw_b});
         chk(e.nm, "nf_bubble",     {15'd0, b_bub},   {15'd0, e.bub_b});
         chk(e.nm, "nf_busy",       {15'd0, b_busy},  {15'd0, e.bz});
         chk(e.nm, "nf_stall_count", {12'd0, b_cnt},  {12'd0, e.cnt_b});
      end
   end

   initial begin
      in_t v;
      reset_n = 1'b0;
      id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      id_muldiv = 1'b0; id_hilo_read = 1'b0; id_jump = 1'b0; ex_branch_taken = 1'b0;
      ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
      mem_reg_write = 1'b0; mem_rd = 5'd0;

      v = '0;                                  step("reset", v, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      v = '0; v.exmr = 1'b1; v.exrw = 1'b1; v.exrd = 5'd8; v.rs = 5'd8; v.urs = 1'b1;
                                               step("load_use", v, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      v = '0;                                  step("after_load_use", v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      v = '0; v.exmr = 1'b1; v.exrw = 1'b1; v.exrd = 5'd0; v.rs = 5'd0; v.urs = 1'b1;
                                               step("rd_zero", v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      v = '0; v.memrw = 1'b1; v.memrd = 5'd9; v.rt = 5'd9; v.urt = 1'b1;
                                               step("mem_raw", v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      v = '0; v.exrw = 1'b1; v.exrd = 5'd5; v.rs = 5'd5; v.urs = 1'b1;
                                               step("ex_raw", v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      v.urs = 1'b0;                            step("ex_raw_unused", v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      v = '0; v.jmp = 1'b1;                    step("jump", v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      v = '0; v.jmp = 1'b1; v.exmr = 1'b1; v.exrw = 1'b1; v.exrd = 5'd3; v.rt = 5'd3; v.urt = 1'b1;
                                               step("jump_vs_stall", v, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      v = '0; v.br = 1'b1; v.md = 1'b1; v.exmr = 1'b1; v.exrw = 1'b1; v.exrd = 5'd8; v.rs = 5'd8; v.urs = 1'b1;
                                               step("branch_override", v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      v = '0; v.md = 1'b1;                     step("md_c0", v, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      v = '0;                                  step("md_c1", v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      v = '0; v.hilo = 1'b1;                   step("md_c2", v, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
                                               step("md_c3", v, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
                                               step("md_c4", v, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      v = '0; v.hilo = 1'b1; v.md = 1'b1;      step("md_c5_reissue", v, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      v = '0; v.md = 1'b1;                     step("md_busy_conflict", v, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      v = '0;                                  step("reset_mid_busy", v, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                                               step("after_reset", v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      v = '0; v.exmr = 1'b1; v.exrw = 1'b1; v.exrd = 5'd8; v.rs = 5'd8; v.urs = 1'b1;
      for (int i = 0; i < 20; i++)             step("sat_stall", v, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      v = '0;                                  step("sat_hold", v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_total++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
